approx_error_monitor: RTL and testbench

APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

---
 rtl/approx_pkg.sv | 17 +
 rtl/error_distance.sv | 17 +
 rtl/approx_error_monitor.sv | 116 +++++++++++
 tb/tb_approx_error_monitor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/approx_pkg.sv
// approx_pkg -- shared state encoding and default sizing for the approximate-adder error monitor.
// rev 1.0
`default_nettype none

package approx_pkg;

  localparam int N_DEF        = 16;
  localparam int LOG2_WIN_DEF = 8;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/error_distance.sv
// error_distance -- unsigned absolute difference between exact and approximate sums.
// rev 1.0
`default_nettype none

module error_distance #(
  parameter int N = 16
) (
  input  logic [N:0] exact,
  input  logic [N:0] approx,
  output logic [N:0] ed
);

  assign ed = (exact >= approx) ? (exact - approx) : (approx - exact);

endmodule

`default_nettype wire

// File: rtl/approx_error_monitor.sv
// approx_error_monitor -- windowed error statistics (count, max, sum of ED) for an approximate adder.
// rev 1.0
`default_nettype none

module approx_error_monitor
  import approx_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int LOG2_WIN = LOG2_WIN_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            x,
  input  logic [N-1:0]            y,
  input  logic [N:0]              sum_approx,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [LOG2_WIN:0]       err_count,
  output logic [N:0]              max_ed,
  output logic [N+LOG2_WIN:0]     sum_ed
);

  localparam int WIN = 1 << LOG2_WIN;
  localparam int CW  = LOG2_WIN + 1;
  localparam int SW  = N + 1 + LOG2_WIN;

  state_e          state_q, state_d;
  logic [CW-1:0]   acc_cnt_q, acc_cnt_d;
  logic            s1_valid_q;
  logic [N:0]      s1_exact_q, s1_approx_q;
  logic [CW-1:0]   err_q, err_d;
  logic [N:0]      max_q, max_d;
  logic [SW-1:0]   sum_q, sum_d;

  logic            accept;
  logic            last_acc;
  logic [N:0]      ed;

  assign in_ready  = (state_q == ACCUM) && (acc_cnt_q < CW'(WIN));
  assign accept    = in_valid && in_ready;
  assign res_valid = (state_q == REPORT);
  assign err_count = err_q;
  assign max_ed    = max_q;
  assign sum_ed    = sum_q;

  // S1 holds the last accepted sample only once the full window has been taken.
  assign last_acc  = s1_valid_q && (acc_cnt_q == CW'(WIN));

  error_distance #(.N(N)) u_ed (
    .exact  (s1_exact_q),
    .approx (s1_approx_q),
    .ed     (ed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
      err_q       <= '0;
      max_q       <= '0;
      sum_q       <= '0;
    end else begin
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      s1_valid_q <= accept;
      err_q      <= err_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
      if (accept) begin
        s1_exact_q  <= {1'b0, x} + {1'b0, y};
        s1_approx_q <= sum_approx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    err_d     = err_q;
    max_d     = max_q;
    sum_d     = sum_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CW'(1);
        end
        if (s1_valid_q) begin
          err_d = err_q + CW'(ed != '0);
          max_d = (ed > max_q) ? ed : max_q;
          sum_d = sum_q + SW'(ed);
        end
        if (last_acc) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          state_d   = ACCUM;
          acc_cnt_d = '0;
          err_d     = '0;
          max_d     = '0;
          sum_d     = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_approx_error_monitor.sv
// tb_approx_error_monitor -- directed self-checking bench, N=16, window of 4.
// rev 1.0
`default_nettype none

module tb_approx_error_monitor;

  localparam int N        = 16;
  localparam int LOG2_WIN = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        x;
  logic [N-1:0]        y;
  logic [N:0]          sum_approx;
  logic                res_valid;
  logic                res_ready;
  logic [LOG2_WIN:0]   err_count;
  logic [N:0]          max_ed;
  logic [N+LOG2_WIN:0] sum_ed;

  int checks = 0;
  int errors = 0;

  approx_error_monitor #(.N(N), .LOG2_WIN(LOG2_WIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .sum_approx (sum_approx),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .err_count  (err_count),
    .max_ed     (max_ed),
    .sum_ed     (sum_ed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one sample for the coming rising edge; it must be accepted there.
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
    @(negedge clk);
    x = a; y = b; sum_approx = s; in_valid = 1'b1;
    check("push_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic check_res(input string tag, input int e, input int m, input int s);
    check({tag, "_err"}, 32'(err_count), 32'(e));
    check({tag, "_max"}, 32'(max_ed), 32'(m));
    check({tag, "_sum"}, 32'(sum_ed), 32'(s));
  endtask

  task automatic handshake();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("hs_res_valid", 32'(res_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);
    check_res("hs_clear", 0, 0, 0);
  endtask

  initial begin
    int acc_n;
    int k4;
    int rv;

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; sum_approx = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check_res("rst", 0, 0, 0);

    // Exact sums: no error at all, yet all four count toward the window.
    push(16'd3, 16'd4, 17'd7);
    push(16'hFFFF, 16'd1, 17'h10000);
    push(16'd100, 16'd200, 17'd300);
    push(16'd0, 16'd0, 17'd0);
    idle();
    wait_res();
    check_res("exact_win", 0, 0, 0);
    check("exact_in_ready", 32'(in_ready), 32'd0);
    handshake();

    // Mixed under/over-estimation: ED = 1, 0x1FFFE, 0, 5.
    push(16'h00FF, 16'h0001, 17'h000FF);
    push(16'hFFFF, 16'hFFFF, 17'h00000);
    push(16'd1, 16'd1, 17'd2);
    push(16'd0, 16'd0, 17'd5);
    idle();
    wait_res();
    check_res("mixed", 3, 32'h1FFFE, 32'h20004);

    // Stall in REPORT while offering junk samples.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = 16'h1234; y = 16'h0001; sum_approx = 17'h0;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_res_valid", 32'(res_valid), 32'd1);
      check("stall_sum", 32'(sum_ed), 32'h20004);
    end
    in_valid = 1'b0;
    check_res("stall_hold", 3, 32'h1FFFE, 32'h20004);
    handshake();

    push(16'd10, 16'd0, 17'd7);
    push(16'd1, 16'd2, 17'd3);
    push(16'd5, 16'd5, 17'd10);
    push(16'd0, 16'd9, 17'd9);
    idle();
    wait_res();
    check_res("after_stall", 1, 3, 3);
    handshake();

    // Reset mid-window discards partial results.
    push(16'd4, 16'd0, 17'd2);
    push(16'd4, 16'd0, 17'd6);
    idle();
    @(negedge clk);
    check_res("running", 2, 2, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_res("midrst", 0, 0, 0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    for (int i = 0; i < 4; i++) push(16'd1, 16'd0, 17'd0);
    idle();
    wait_res();
    check_res("post_rst", 4, 1, 4);
    handshake();

    // Back-to-back stream with in_valid held high.
    acc_n = 0; k4 = -1; rv = -1;
    @(negedge clk);
    in_valid = 1'b1; x = '0; y = '0; sum_approx = '0;
    for (int i = 0; i < 12; i++) begin
      if (res_valid && rv < 0) rv = i;
      if (in_valid && in_ready) begin
        acc_n++;
        if (acc_n == 4) k4 = i;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stream_accepts", 32'(acc_n), 32'd4);
    check("stream_k4", 32'(k4), 32'd3);
    check("stream_res_lat", 32'(rv - k4), 32'd2);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
